pin_display_scanner: RTL

//  Reads out the 8-digit lock code held in the UI/SP shift-register arrays and

---
 rtl/pin_display_scanner.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pin_display_scanner.sv
// pin_display_scanner
//   Decode end of the keypad path: snapshots the entered lock code on load and
//   scans it onto a multiplexed 7-segment display, one position per DWELL
//   cycles. Positions not yet entered are blanked; the last entered digit
//   lights the decimal point as a cursor marker.
//
// Optional build macro: PIN_MASK_EN adds the mask input, which replaces every
//   entered digit with a dash.
//
// Ports
//   clk     rising-edge system clock
//   rst     asynchronous reset, active-high
//   digits  packed BCD code, digit1 in the top nibble
//   count   digits entered so far, saturates at NDIG
//   load    1-cycle strobe: snapshot digits/count and restart the scan
//   en      display enable
//   mask    (PIN_MASK_EN only) 1 = show dashes instead of digit values
//   seg     segments {g,f,e,d,c,b,a}, active-high, registered
//   an      one-hot position select, an[NDIG-1] = digit1, registered
//   dp      decimal point / cursor marker, registered
module pin_display_scanner #(
    parameter int unsigned NDIG  = 8,
    parameter int unsigned DWELL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4*NDIG-1:0] digits,
    input  logic [3:0]        count,
    input  logic              load,
    input  logic              en,
`ifdef PIN_MASK_EN
    input  logic              mask,
`endif
    output logic [6:0]        seg,
    output logic [NDIG-1:0]   an,
    output logic              dp
);

    localparam int unsigned    IW         = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned    DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [IW-1:0]  IDX_LAST   = IW'(NDIG - 1);
    localparam logic [DW-1:0]  DWELL_LAST = DW'(DWELL - 1);
    localparam logic [3:0]     CNT_MAX    = 4'(NDIG);

    typedef enum logic {
        OFF,
        SCAN
    } state_e;

    state_e            state_q;
    logic [4*NDIG-1:0] shadow_q;
    logic [3:0]        cnt_q;
    logic [IW-1:0]     idx_q;
    logic [DW-1:0]     dwell_q;
    logic [6:0]        seg_q;
    logic [NDIG-1:0]   an_q;
    logic              dp_q;

    logic [6:0]        seg_d;
    logic [NDIG-1:0]   an_d;
    logic              dp_d;
    logic [3:0]        cnt_d;

    int unsigned       pos;
    logic [3:0]        nib;
    logic [6:0]        glyph;
    logic              blank;

    // Display image of the position currently selected by idx_q.
    always_comb begin
        pos   = 32'(idx_q);
        nib   = 4'(shadow_q >> (4 * (NDIG - 1 - pos)));
        blank = (pos >= 32'(cnt_q));
        case (nib)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = 7'h79;
        endcase
`ifdef PIN_MASK_EN
        if (mask) begin
            glyph = 7'h40;
        end
`endif
        seg_d = blank ? '0 : glyph;
        // count==0 must never light the cursor, so guard before the subtract.
        dp_d  = (cnt_q != '0) && (pos == 32'(cnt_q) - 1);
        for (int unsigned i = 0; i < NDIG; i++) begin
            an_d[i] = (i == NDIG - 1 - pos);
        end
    end

    assign cnt_d = (count > CNT_MAX) ? CNT_MAX : count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= OFF;
            shadow_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            dwell_q  <= '0;
            seg_q    <= '0;
            an_q     <= '0;
            dp_q     <= '0;
        end else begin
            case (state_q)
                OFF:     if (en)  state_q <= SCAN;
                SCAN:    if (!en) state_q <= OFF;
                default: state_q <= OFF;
            endcase

            // Outputs follow the state being entered so en acts with the same
            // one-cycle latency as every other input.
            if (en) begin
                seg_q <= seg_d;
                an_q  <= an_d;
                dp_q  <= dp_d;
            end else begin
                seg_q <= '0;
                an_q  <= '0;
                dp_q  <= '0;
            end

            if (load) begin
                shadow_q <= digits;
                cnt_q    <= cnt_d;
                idx_q    <= '0;
                dwell_q  <= '0;
            end else if (en) begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_q <= '0;
                    idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end else begin
                    dwell_q <= dwell_q + 1'b1;
                end
            end
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule
